// File: rtl/scan_ctrl_generic_if.sv
// Handshake and chain-side signals of the scan-chain controller.
// The slave modport is the controller; the master modport is the
// test/debug side together with the chain that feeds SCANOUT back.
interface scan_ctrl_generic_if #(
  parameter int N = 8
);
  logic         START;
  logic         NOCAP;
  logic [N-1:0] VEC_IN;
  logic         SCANOUT;
  logic         TEST;
  logic         SCANIN;
  logic [N-1:0] RESP;
  logic         BUSY;
  logic         DONE;

  modport master (
    output START, NOCAP, VEC_IN, SCANOUT,
    input  TEST, SCANIN, RESP, BUSY, DONE
  );

  modport slave (
    input  START, NOCAP, VEC_IN, SCANOUT,
    output TEST, SCANIN, RESP, BUSY, DONE
  );
endinterface

// File: rtl/scan_ctrl_generic.sv
// Scan-chain controller: shifts a vector into an N-bit scan chain, pulses
// one functional capture cycle, then unloads the response into RESP.
// In readback-only mode (NOCAP) the old chain contents are collected while
// the vector is shifted in, with no capture and no unload phase.
// All outputs are registered so TEST/SCANIN settle a full cycle before the
// chain samples them.
module scan_ctrl_generic #(
  parameter int   N    = 8,
  parameter int   CW   = 4,
  parameter logic FILL = 1'b0
) (
  input logic           CLK,
  input logic           CLR,
  scan_ctrl_generic_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CAPT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t       state_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0] vec_r;     // remaining vector bits, next bit to send at MSB
  logic         nocap_r;
  logic         last_s;

  // The N-th shift of a phase happens on the edge where the counter reads N-1.
  assign last_s = (cnt_r == CW'(N - 1));

  // Sequencer: state, counter, vector shifter and all registered outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      vec_r      <= {N{1'b0}};
      nocap_r    <= 1'b0;
      bus.TEST   <= 1'b0;
      bus.SCANIN <= 1'b0;
      bus.RESP   <= {N{1'b0}};
      bus.BUSY   <= 1'b0;
      bus.DONE   <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.START) begin
            // MSB goes out on SCANIN now; the rest waits pre-shifted in vec_r.
            vec_r      <= {bus.VEC_IN[N-2:0], 1'b0};
            nocap_r    <= bus.NOCAP;
            bus.TEST   <= 1'b1;
            bus.SCANIN <= bus.VEC_IN[N-1];
            cnt_r      <= {CW{1'b0}};
            bus.BUSY   <= 1'b1;
            state_r    <= LOAD;
          end else begin
            bus.TEST   <= 1'b0;
            bus.SCANIN <= 1'b0;
            bus.BUSY   <= 1'b0;
          end
        end
        LOAD: begin
          bus.SCANIN <= vec_r[N-1];
          vec_r      <= {vec_r[N-2:0], 1'b0};
          cnt_r      <= cnt_r + CW'(1);
          if (nocap_r) begin
            // Readback: the chain's old contents fall out while the vector goes in.
            bus.RESP <= {bus.RESP[N-2:0], bus.SCANOUT};
          end else begin
            bus.RESP <= bus.RESP;
          end
          if (last_s) begin
            bus.TEST <= 1'b0;
            if (nocap_r) begin
              bus.SCANIN <= 1'b0;
              bus.DONE   <= 1'b1;
              bus.BUSY   <= 1'b0;
              state_r    <= IDLE;
            end else begin
              state_r    <= CAPT;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        CAPT: begin
          // The chain does its functional update on this edge with TEST low.
          bus.TEST   <= 1'b1;
          bus.SCANIN <= FILL;
          cnt_r      <= {CW{1'b0}};
          state_r    <= UNLOAD;
        end
        UNLOAD: begin
          bus.RESP <= {bus.RESP[N-2:0], bus.SCANOUT};
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            bus.TEST   <= 1'b0;
            bus.SCANIN <= 1'b0;
            bus.DONE   <= 1'b1;
            bus.BUSY   <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r <= UNLOAD;
          end
        end
        default: begin
          state_r    <= IDLE;
          bus.TEST   <= 1'b0;
          bus.SCANIN <= 1'b0;
          bus.BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_ctrl_generic.sv
// Directed bench for scan_ctrl_generic with an 8-bit JK scan-chain model.
module tb_scan_ctrl_generic;

  localparam int N = 8;

  logic CLK;
  logic CLR;

  scan_ctrl_generic_if #(.N(N)) bus ();

  scan_ctrl_generic #(.N(N), .CW(4), .FILL(1'b0)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  // Chain model: scan shift when TEST, otherwise JK update (Q+ = J&~Q | ~K&Q, J=K=jk).
  logic [N-1:0] chain_q;
  logic [N-1:0] jk;
  logic [N-1:0] pre_val;
  logic         pre_en;

  always @(posedge CLK) begin
    if (pre_en)        chain_q <= pre_val;
    else if (bus.TEST) chain_q <= {chain_q[N-2:0], bus.SCANIN};
    else               chain_q <= (jk & ~chain_q) | (~jk & chain_q);
  end

  assign bus.SCANOUT = chain_q[N-1];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pre;
    logic [7:0] vec;
    logic       nc;
    logic [7:0] jkv;
    int         glitch;
    logic [7:0] exp_resp;
    logic [7:0] exp_chain;
  } rec_t;

  rec_t tbl [6];

  // One full operation; sample index k is the cycle after edge e_k (e0 = START edge).
  task automatic run_op(input rec_t r);
    int lat, done_at, done_cnt, busy_cnt, tbad;
    logic exp_t;
    logic [7:0] resp_s, chain_s;
    @(negedge CLK);
    pre_val = r.pre; pre_en = 1'b1;
    @(negedge CLK);
    pre_en = 1'b0;
    bus.START = 1'b1; bus.VEC_IN = r.vec; bus.NOCAP = r.nc;
    @(posedge CLK);
    #1;
    bus.START = 1'b0; bus.VEC_IN = 8'h00; bus.NOCAP = 1'b0;
    jk = r.jkv;
    lat = r.nc ? 8 : 17;
    done_at = -1; done_cnt = 0; busy_cnt = 0; tbad = 0;
    resp_s = 8'h00; chain_s = 8'h00;
    for (int k = 0; k <= lat + 2; k++) begin
      @(negedge CLK);
      if (r.glitch >= 0 && k == r.glitch) begin
        bus.START = 1'b1; bus.VEC_IN = 8'hFF; bus.NOCAP = 1'b1;
      end else if (r.glitch >= 0 && k == r.glitch + 1) begin
        bus.START = 1'b0; bus.VEC_IN = 8'h00; bus.NOCAP = 1'b0;
      end
      exp_t = r.nc ? (k < 8) : ((k < 8) || (k > 8 && k <= 16));
      if (bus.TEST !== exp_t) tbad++;
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (bus.DONE === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == lat) begin
        resp_s  = bus.RESP;
        chain_s = chain_q;
      end
    end
    jk = 8'h00;
    chk("done_latency", done_at, lat);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, r.nc ? 8 : 17);
    chk("test_pattern_bad", tbad, 0);
    chk("resp", resp_s, r.exp_resp);
    chk("chain", chain_s, r.exp_chain);
  endtask

  initial begin
    int bad, dn;
    bus.START = 1'b0; bus.NOCAP = 1'b0; bus.VEC_IN = 8'h00;
    jk = 8'h00; pre_val = 8'h00; pre_en = 1'b0;
    CLR = 1'b1;

    //            pre    vec    nc    jk     glitch resp   chain
    tbl[0] = '{8'h00, 8'hA5, 1'b0, 8'h00, -1, 8'hA5, 8'h00};
    tbl[1] = '{8'h00, 8'hA5, 1'b0, 8'hFF, -1, 8'h5A, 8'h00};
    tbl[2] = '{8'h3C, 8'hC3, 1'b1, 8'h00, -1, 8'h3C, 8'hC3};
    tbl[3] = '{8'h00, 8'h96, 1'b0, 8'h0F, -1, 8'h99, 8'h00};
    tbl[4] = '{8'hE1, 8'h1E, 1'b1, 8'h00, -1, 8'hE1, 8'h1E};
    tbl[5] = '{8'h00, 8'hA5, 1'b0, 8'h00,  5, 8'hA5, 8'h00};

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_test", bus.TEST, 1'b0);
    chk("rst_scanin", bus.SCANIN, 1'b0);
    chk("rst_resp", bus.RESP, 8'h00);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    @(negedge CLK);
    CLR = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // Abort in the middle of UNLOAD with CLR between edges.
    @(negedge CLK);
    bus.START = 1'b1; bus.VEC_IN = 8'hA5; bus.NOCAP = 1'b0;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    repeat (12) @(negedge CLK);
    chk("pre_abort_busy", bus.BUSY, 1'b1);
    #2 CLR = 1'b1;
    #1;
    chk("abort_test", bus.TEST, 1'b0);
    chk("abort_scanin", bus.SCANIN, 1'b0);
    chk("abort_busy", bus.BUSY, 1'b0);
    chk("abort_resp", bus.RESP, 8'h00);
    #1 CLR = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_op(tbl[0]);

    // START held high: back-to-back readback operations.
    @(negedge CLK);
    pre_val = 8'h96; pre_en = 1'b1;
    @(negedge CLK);
    pre_en = 1'b0;
    bus.START = 1'b1; bus.VEC_IN = 8'hA5; bus.NOCAP = 1'b1;
    @(posedge CLK);
    bad = 0;
    for (int k = 0; k <= 26; k++) begin
      @(negedge CLK);
      if (bus.DONE !== ((k == 8) || (k == 17) || (k == 26))) bad++;
      if (k == 8) begin
        chk("b2b_resp1", bus.RESP, 8'h96);
        bus.VEC_IN = 8'h3C;
      end
      if (k == 9)  chk("b2b_busy_again", bus.BUSY, 1'b1);
      if (k == 17) chk("b2b_resp2", bus.RESP, 8'hA5);
      if (k == 26) chk("b2b_resp3", bus.RESP, 8'h3C);
    end
    chk("b2b_done_pulses", bad, 0);
    bus.START = 1'b0;
    repeat (12) @(negedge CLK);
    chk("b2b_idle", bus.BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_ctrl_generic.md
# scan_ctrl_generic

Scan-chain controller that drives the TEST/SCANIN side of an N-bit scan-capable register chain and reads it back through the chain's last bit. On START it shifts a test vector in and pulses one functional capture clock. It then shifts the captured response out into a parallel register and flags DONE. A readback-only mode swaps the vector for the chain contents without a capture. It sits between a test/debug master and any chain of scan flip-flops, where each shift edge does Q = {Q[N-2:0], SCANIN}.

## Interface
- N, default 8: chain length in bits (≥2).
- CW, default 4: shift-counter width; 2^CW ≥ N required.
- FILL, default 1'b0: value driven on SCANIN during UNLOAD.

- CLK  in  1  rising-edge clock, shared with the chain.
- CLR  in  1  reset, asynchronous and active-high.
- START  in  1  request; sampled only in IDLE.
- NOCAP  in  1  sampled with START. 1 selects readback-only mode (no capture, no unload).
- VEC_IN  in  N  test vector, sampled with START.
- SCANOUT  in  1  chain Q[N-1].
- TEST  out  1  chain scan-enable, registered.
- SCANIN  out  1  chain serial input, registered.
- RESP  out  N  response collected from SCANOUT, registered.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- Reset (CLR=1, immediate, async): state IDLE, TEST=0, SCANIN=0, RESP=0, BUSY=0, DONE=0, counter=0, vector register=0.
- States: IDLE, LOAD, CAPT, UNLOAD.
- IDLE, START=1 at an edge:
  - Latch VEC_IN and NOCAP.
  - TEST←1, SCANIN←VEC_IN[N-1], counter←0, go to LOAD.
  - START=0: TEST=0, SCANIN=0.
- LOAD, one edge per bit, N edges:
  - The chain shifts on every edge.
  - The controller drives SCANIN with vector bits N-1 down to 0, MSB first.
  - At the edge where counter=N-1:
    - NOCAP=0: TEST←0, go to CAPT.
    - NOCAP=1: TEST←0, SCANIN←0, DONE←1, go to IDLE.
- NOCAP=1 only: during LOAD, each edge also does RESP←{RESP[N-2:0], SCANOUT}. After N edges, RESP holds the chain's prior contents. The chain holds the vector.
- CAPT, exactly one edge:
  - The chain performs its functional update (TEST=0).
  - Controller: TEST←1, SCANIN←FILL, counter←0, go to UNLOAD.
- UNLOAD, N edges:
  - Each edge: RESP←{RESP[N-2:0], SCANOUT}. The pre-edge SCANOUT is sampled, so response bit N-1 is taken first.
  - At counter=N-1: TEST←0, SCANIN←0, DONE←1, go to IDLE.
- RESP keeps its value until the next read phase begins. It does not clear on START.
- START while BUSY is ignored. NOCAP and VEC_IN are ignored except at the accepting edge.
- DONE is high for exactly one cycle. START may be accepted on the same edge that DONE falls: back-to-back operation.
- Counter arithmetic is unsigned CW-bit, compared against N-1. The counter never wraps within a legal configuration.

## Timing
- Edge e0 accepts START. TEST is high for edges e1..eN.
- Normal mode:
  - eN+1 is the capture edge (TEST=0).
  - eN+2..e2N+1 are the unload edges.
  - DONE is high in the cycle after e2N+1.
  - BUSY is high from after e0 through e2N+1: 2N+1 cycles.
- NOCAP mode: DONE is high after eN. BUSY lasts N cycles.
- TEST and SCANIN change only just after rising edges, so they are stable a full cycle before the chain samples them.
- CLR mid-operation aborts at once:
  - No DONE is issued.
  - RESP=0.
  - Chain contents are undefined from the controller's view.

## Test plan
- N=8, chain model with J=K=0 (hold). START, VEC_IN=8'hA5, NOCAP=0 -> TEST high for 8 cycles, low for 1, high for 8. RESP=8'hA5. DONE pulse 17 cycles after the START edge. Chain finally holds 8'h00 (FILL=0).
- Same, chain J=K=8'hFF (toggle) -> RESP=8'h5A.
- Chain preloaded 8'h3C. START, VEC_IN=8'hC3, NOCAP=1 -> RESP=8'h3C, chain=8'hC3, TEST never drops mid-operation, DONE 8 cycles after START.
- START pulsed again at cycle 5 of LOAD with VEC_IN=8'hFF -> ignored. Result identical to the first scenario. Single DONE.
- CLR asserted mid-UNLOAD, between two clock edges -> TEST, SCANIN, BUSY, RESP go to 0 immediately. No DONE. The next START runs a full sequence.
- START held high continuously -> operations run back-to-back. Each new START is accepted on the edge where DONE falls, and each DONE pulse lasts 1 cycle.
